// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its request/response front end.
package alu_pkg;

  typedef enum logic [2:0] {
    ADD = 3'b000,
    SUB = 3'b001,
    AND = 3'b010,
    OR  = 3'b011,
    XOR = 3'b100,
    NOT = 3'b101,
    SHL = 3'b110,
    SHR = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/alu_req_ctrl.sv
// Request/response front end for the combinational ALU. One operation is in
// flight at a time: accept -> drive ALU for one cycle -> hold response until
// consumed. Supports chaining the previous result back in as operand a.
module alu_req_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int TAG_W   = 4,
  parameter int COUNT_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [WIDTH-1:0]   req_a,
  input  logic [WIDTH-1:0]   req_b,
  input  logic [2:0]         req_op,
  input  logic [TAG_W-1:0]   req_tag,
  input  logic               req_chain,
  output logic [WIDTH-1:0]   alu_a,
  output logic [WIDTH-1:0]   alu_b,
  output logic [2:0]         alu_op,
  input  logic [WIDTH-1:0]   alu_result,
  input  logic               alu_zero,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [WIDTH-1:0]   rsp_result,
  output logic               rsp_zero,
  output logic [TAG_W-1:0]   rsp_tag,
  output logic [COUNT_W-1:0] op_count
);

  state_e           state;
  alu_op_e          op_q;
  logic [WIDTH-1:0] last_result;

  // Handshake flags come straight from the state register, so req_ready never
  // depends on rsp_ready and a new request cannot overlap a pending response.
  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign alu_op    = op_q;

  // Single FSM: issue operands on accept, capture ALU output after one cycle,
  // hold the response until it is consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      alu_a       <= '0;
      alu_b       <= '0;
      op_q        <= ADD;
      rsp_tag     <= '0;
      rsp_result  <= '0;
      rsp_zero    <= 1'b0;
      last_result <= '0;
      op_count    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            // Chaining sees last_result as it stands at this accept edge.
            alu_a   <= req_chain ? last_result : req_a;
            alu_b   <= req_b;
            op_q    <= alu_op_e'(req_op);
            rsp_tag <= req_tag;
            state   <= EXEC;
          end
        end
        EXEC: begin
          // ALU has had a full cycle to settle on the registered operands.
          rsp_result  <= alu_result;
          rsp_zero    <= alu_zero;
          last_result <= alu_result;
          state       <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            op_count <= op_count + COUNT_W'(1);
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_req_ctrl.sv
// Self-checking bench for alu_req_ctrl. The bench plays the parent role and
// provides a behavioural ALU; expected results come from a transaction-level
// model (last result + completed count) driven by the same request stream.
module tb_alu_req_ctrl;
  import alu_pkg::*;

  localparam int WIDTH   = 8;
  localparam int TAG_W   = 4;
  localparam int COUNT_W = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic               req_valid;
  logic               req_ready;
  logic [WIDTH-1:0]   req_a, req_b;
  logic [2:0]         req_op;
  logic [TAG_W-1:0]   req_tag;
  logic               req_chain;
  logic [WIDTH-1:0]   alu_a, alu_b;
  logic [2:0]         alu_op;
  logic [WIDTH-1:0]   alu_result;
  logic               alu_zero;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [WIDTH-1:0]   rsp_result;
  logic               rsp_zero;
  logic [TAG_W-1:0]   rsp_tag;
  logic [COUNT_W-1:0] op_count;

  int checks = 0;
  int errors = 0;

  // Transaction-level reference state.
  logic [WIDTH-1:0] m_last;
  int               m_count;

  always #5 clk = ~clk;

  alu_req_ctrl #(.WIDTH(WIDTH), .TAG_W(TAG_W), .COUNT_W(COUNT_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_tag(req_tag),
    .req_chain(req_chain),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_tag(rsp_tag),
    .op_count(op_count)
  );

  function automatic logic [WIDTH-1:0] ref_alu(input logic [2:0] op,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    case (op)
      3'b000:  return a + b;
      3'b001:  return a - b;
      3'b010:  return a & b;
      3'b011:  return a | b;
      3'b100:  return a ^ b;
      3'b101:  return ~a;
      3'b110:  return a << 1;
      default: return a >> 1;
    endcase
  endfunction

  // Behavioural stand-in for the parent's combinational ALU.
  assign alu_result = ref_alu(alu_op, alu_a, alu_b);
  assign alu_zero   = (alu_result == '0);

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance model by one completed operation; returns expected result.
  task automatic model_step(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input logic [2:0] op, input logic chain,
                            output logic [WIDTH-1:0] exp_a,
                            output logic [WIDTH-1:0] exp_res);
    exp_a   = chain ? m_last : a;
    exp_res = ref_alu(op, exp_a, b);
    m_last  = exp_res;
    m_count = m_count + 1;
  endtask

  task automatic model_reset();
    m_last  = '0;
    m_count = 0;
  endtask

  // Drive one request and consume its response after 'hold' extra cycles.
  // Called and returns at 1 time unit after a rising edge.
  task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic [2:0] op, input logic [TAG_W-1:0] tag,
                       input logic chain, input int hold,
                       output logic [WIDTH-1:0] res, output logic z,
                       output logic [TAG_W-1:0] t, output int lat,
                       output longint acc_t, output bit to);
    int w;
    to = 1'b0; lat = 0; acc_t = 0; res = '0; z = 1'b0; t = '0;
    req_a = a; req_b = b; req_op = op; req_tag = tag; req_chain = chain;
    req_valid = 1'b1;
    w = 0;
    while (!req_ready && w < 20) begin @(posedge clk); #1; w++; end
    if (!req_ready) begin to = 1'b1; req_valid = 1'b0; return; end
    @(posedge clk);
    acc_t = $time;
    #1;
    req_valid = 1'b0;
    req_a = 8'($urandom); req_b = 8'($urandom); req_chain = 1'($urandom);
    while (!rsp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    if (!rsp_valid) begin to = 1'b1; return; end
    repeat (hold) begin @(posedge clk); #1; end
    res = rsp_result; z = rsp_zero; t = rsp_tag;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    // Hold a request and a response-ready during reset; reset must win.
    rst = 1'b1; req_valid = 1'b1; rsp_ready = 1'b1;
    req_a = 8'hA5; req_b = 8'h5A; req_op = 3'b100; req_tag = 4'hF; req_chain = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({req_ready, rsp_valid} !== 2'b10) begin
      errors++; $display("FAIL reset_flags: ready/valid=%b required 10", {req_ready, rsp_valid});
    end
    checks++;
    if ({rsp_result, rsp_zero, rsp_tag} !== '0) begin
      errors++; $display("FAIL reset_rsp: result=%h zero=%b tag=%h required all 0", rsp_result, rsp_zero, rsp_tag);
    end
    checks++;
    if ({alu_a, alu_b, alu_op} !== '0) begin
      errors++; $display("FAIL reset_alu: a=%h b=%h op=%b required all 0", alu_a, alu_b, alu_op);
    end
    checks++;
    if (op_count !== '0) begin
      errors++; $display("FAIL reset_count: op_count=%0d required 0", op_count);
    end
    rst = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
    model_reset();
    @(posedge clk); #1;
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL reset_idle: ready=%b valid=%b required 1 0", req_ready, rsp_valid);
    end
  endtask

  task automatic test_basic();
    logic [WIDTH-1:0] res, ea, er; logic z; logic [TAG_W-1:0] t; int lat; longint at; bit to;
    issue(8'd10, 8'd5, ADD, 4'd3, 1'b0, 0, res, z, t, lat, at, to);
    model_step(8'd10, 8'd5, ADD, 1'b0, ea, er);
    checks++;
    if (to) begin errors++; $display("FAIL basic_timeout: handshake timed out"); end
    checks++;
    if (lat !== 1) begin
      errors++; $display("FAIL basic_latency: rsp_valid rose %0d edges after accept, required 1", lat);
    end
    checks++;
    if (res !== 8'd15 || z !== 1'b0 || t !== 4'd3) begin
      errors++; $display("FAIL basic_add: result=%0d zero=%b tag=%0d required 15 0 3", res, z, t);
    end
    checks++;
    if (op_count !== COUNT_W'(m_count)) begin
      errors++; $display("FAIL basic_count: op_count=%0d required %0d", op_count, m_count % 16);
    end
  endtask

  task automatic test_chain();
    logic [WIDTH-1:0] res, ea, er; logic z; logic [TAG_W-1:0] t; int lat; longint at; bit to;
    issue(8'd10, 8'd5, SUB, 4'd1, 1'b0, 0, res, z, t, lat, at, to);
    model_step(8'd10, 8'd5, SUB, 1'b0, ea, er);
    checks++;
    if (to || res !== 8'd5 || z !== 1'b0) begin
      errors++; $display("FAIL chain_sub: result=%0d zero=%b to=%b required 5 0", res, z, to);
    end
    issue(8'd99, 8'd3, ADD, 4'd2, 1'b1, 1, res, z, t, lat, at, to);
    model_step(8'd99, 8'd3, ADD, 1'b1, ea, er);
    checks++;
    if (to || res !== 8'd8 || z !== 1'b0 || t !== 4'd2) begin
      errors++; $display("FAIL chain_add: result=%0d zero=%b tag=%0d required 8 0 2", res, z, t);
    end
    checks++;
    if (alu_a !== 8'd8 - 8'd3 + 8'd0 || alu_b !== 8'd3) begin
      errors++; $display("FAIL chain_alu_hold: alu_a=%0d alu_b=%0d required 5 3", alu_a, alu_b);
    end
    issue(8'd77, 8'd8, XOR, 4'd4, 1'b1, 0, res, z, t, lat, at, to);
    model_step(8'd77, 8'd8, XOR, 1'b1, ea, er);
    checks++;
    if (to || res !== 8'd0 || z !== 1'b1) begin
      errors++; $display("FAIL chain_xor: result=%0d zero=%b required 0 1", res, z);
    end
  endtask

  task automatic test_zero_wrap();
    logic [WIDTH-1:0] res, ea, er; logic z; logic [TAG_W-1:0] t; int lat; longint at; bit to;
    issue(8'd0, 8'd0, ADD, 4'd5, 1'b0, 0, res, z, t, lat, at, to);
    model_step(8'd0, 8'd0, ADD, 1'b0, ea, er);
    checks++;
    if (to || res !== 8'd0 || z !== 1'b1) begin
      errors++; $display("FAIL zero_add: result=%0d zero=%b required 0 1", res, z);
    end
    issue(8'd255, 8'd1, ADD, 4'd6, 1'b0, 0, res, z, t, lat, at, to);
    model_step(8'd255, 8'd1, ADD, 1'b0, ea, er);
    checks++;
    if (to || res !== 8'd0 || z !== 1'b1 || t !== 4'd6) begin
      errors++; $display("FAIL wrap_add: result=%0d zero=%b tag=%0d required 0 1 6", res, z, t);
    end
  endtask

  task automatic test_backpressure();
    logic [WIDTH-1:0] ea, er, h_res; logic h_z; logic [TAG_W-1:0] h_tag;
    int cnt0, w, extra;
    cnt0 = m_count;
    req_a = 8'd40; req_b = 8'd2; req_op = SUB; req_tag = 4'd9; req_chain = 1'b0;
    req_valid = 1'b1;
    @(posedge clk); #1;
    model_step(8'd40, 8'd2, SUB, 1'b0, ea, er);
    req_a = 8'd1; req_b = 8'd1; req_tag = 4'd7;
    w = 0;
    while (!rsp_valid && w < 10) begin @(posedge clk); #1; w++; end
    checks++;
    if (!rsp_valid) begin errors++; $display("FAIL bp_timeout: no response within 10 cycles"); end
    h_res = rsp_result; h_z = rsp_zero; h_tag = rsp_tag;
    checks++;
    if (h_res !== er || h_z !== (er == '0) || h_tag !== 4'd9) begin
      errors++; $display("FAIL bp_value: result=%0d zero=%b tag=%0d required %0d %b 9", h_res, h_z, h_tag, er, er == '0);
    end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checks++;
      if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_result !== h_res ||
          rsp_zero !== h_z || rsp_tag !== h_tag) begin
        errors++;
        $display("FAIL bp_hold: cycle %0d valid=%b ready=%b result=%0d tag=%0d required 1 0 %0d %0d",
                 i, rsp_valid, req_ready, rsp_result, rsp_tag, h_res, h_tag);
      end
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    extra = 0;
    for (int i = 0; i < 3; i++) begin
      if (rsp_valid) extra++;
      @(posedge clk); #1;
    end
    checks++;
    if (extra != 0 || op_count !== COUNT_W'(cnt0 + 1)) begin
      errors++; $display("FAIL bp_single: extra_valid_cycles=%0d op_count=%0d required 0 %0d", extra, op_count, (cnt0 + 1) % 16);
    end
  endtask

  task automatic test_reset_exec();
    int seen;
    req_a = 8'd12; req_b = 8'd34; req_op = ADD; req_tag = 4'd8; req_chain = 1'b0;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || op_count !== '0) begin
      errors++; $display("FAIL rst_exec: ready=%b valid=%b op_count=%0d required 1 0 0", req_ready, rsp_valid, op_count);
    end
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (rsp_valid) seen++;
      @(posedge clk); #1;
    end
    checks++;
    if (seen != 0 || rsp_result !== '0) begin
      errors++; $display("FAIL rst_exec_norsp: valid_cycles=%0d result=%0d required 0 0", seen, rsp_result);
    end
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] a, b, res, ea, er; logic [2:0] op; logic [TAG_W-1:0] tg, t;
    logic ch, z; int lat; longint at; bit to;
    for (int i = 0; i < 30; i++) begin
      a = 8'($urandom); b = 8'($urandom); op = 3'($urandom); tg = 4'($urandom);
      ch = 1'($urandom);
      issue(a, b, op, tg, ch, int'($urandom_range(0, 3)), res, z, t, lat, at, to);
      model_step(a, b, op, ch, ea, er);
      checks++;
      if (to || res !== er || z !== (er == '0) || t !== tg) begin
        errors++;
        $display("FAIL rand_%0d: op=%b a=%h b=%h chain=%b result=%h zero=%b tag=%h required %h %b %h",
                 i, op, a, b, ch, res, z, t, er, er == '0, tg);
      end
      checks++;
      if (alu_a !== ea || alu_b !== b || alu_op !== op || op_count !== COUNT_W'(m_count)) begin
        errors++;
        $display("FAIL rand_hold_%0d: alu_a=%h alu_b=%h alu_op=%b op_count=%0d required %h %h %b %0d",
                 i, alu_a, alu_b, alu_op, op_count, ea, b, op, m_count % 16);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] a, b, res, ea, er; logic [2:0] op; logic [TAG_W-1:0] t;
    logic ch, z; int lat; longint at, prev_t; bit to;
    int bad_iv, bad_res;
    do_reset();
    bad_iv = 0; bad_res = 0; prev_t = 0;
    for (int i = 0; i < 17; i++) begin
      a = 8'($urandom); b = 8'($urandom); op = 3'($urandom); ch = 1'($urandom);
      issue(a, b, op, 4'(i), ch, 0, res, z, t, lat, at, to);
      model_step(a, b, op, ch, ea, er);
      if (to || res !== er || z !== (er == '0) || t !== 4'(i)) bad_res++;
      if (i > 0 && (at - prev_t) != 30) bad_iv++;
      prev_t = at;
    end
    checks++;
    if (bad_res != 0) begin
      errors++; $display("FAIL b2b_results: %0d of 17 responses wrong, required 0", bad_res);
    end
    checks++;
    if (bad_iv != 0) begin
      errors++; $display("FAIL b2b_interval: %0d intervals not 3 cycles, required 0", bad_iv);
    end
    checks++;
    if (op_count !== 4'd1) begin
      errors++; $display("FAIL b2b_wrap: op_count=%0d required 1", op_count);
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
    req_a = '0; req_b = '0; req_op = '0; req_tag = '0; req_chain = 1'b0;
    model_reset();
    test_reset();
    test_basic();
    test_chain();
    test_zero_wrap();
    test_backpressure();
    test_random();
    test_reset_exec();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
